// File: rtl/nms_window_core.sv
// Raster-order non-maximum suppression over an NMS_SIZE x NMS_SIZE window with internal line buffers.
// Build option: `define NMS_SCORE_THRESH_EN adds the score_thresh input (corner needs centre > score_thresh).
module nms_window_core #(
    parameter int COL_NUM  = 640,
    parameter int ROW_NUM  = 480,
    parameter int NMS_SIZE = 3,
    parameter int SCORE_W  = 13,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               sof,
    input  logic [SCORE_W-1:0] score_in,
`ifdef NMS_SCORE_THRESH_EN
    input  logic [SCORE_W-1:0] score_thresh,
`endif
    output logic               out_vld,
    output logic               corner_out,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [SCORE_W-1:0] score_out
);
    localparam int R    = (NMS_SIZE - 1) / 2;
    localparam int SPAN = 2 * R;

    logic [X_W-1:0]     r_col;
    logic [Y_W-1:0]     r_row;
    logic [X_W-1:0]     w_col;
    logic [X_W-1:0]     w_col_nxt;
    logic [Y_W-1:0]     w_row;
    logic [Y_W-1:0]     w_row_nxt;
    logic               w_eligible;

    logic [SCORE_W-1:0] r_lb      [NMS_SIZE-1][COL_NUM];
    logic [SCORE_W-1:0] w_lb_rd   [NMS_SIZE-1];
    logic [SCORE_W-1:0] w_col_vec [NMS_SIZE];
    logic [SCORE_W-1:0] r_win     [NMS_SIZE][NMS_SIZE];

    logic               r_s1_vld;
    logic [X_W-1:0]     r_s1_x;
    logic [Y_W-1:0]     r_s1_y;
    logic [SCORE_W-1:0] w_centre;
    logic [SCORE_W-1:0] w_thresh;
    logic               w_is_max;

`ifdef NMS_SCORE_THRESH_EN
    assign w_thresh = score_thresh;
`else
    assign w_thresh = {SCORE_W{1'b0}};
`endif

    // Pixel coordinate of the current input; sof makes a same-cycle pixel (0,0).
    always_comb begin
        w_col      = sof ? {X_W{1'b0}} : r_col;
        w_row      = sof ? {Y_W{1'b0}} : r_row;
        w_col_nxt  = w_col + X_W'(1);
        w_row_nxt  = w_row;
        if (w_col == X_W'(COL_NUM - 1)) begin
            w_col_nxt = {X_W{1'b0}};
            if (w_row == Y_W'(ROW_NUM - 1)) begin
                w_row_nxt = {Y_W{1'b0}};
            end else begin
                w_row_nxt = w_row + Y_W'(1);
            end
        end else begin
            w_row_nxt = w_row;
        end
        w_eligible = (w_col >= X_W'(SPAN)) && (w_row >= Y_W'(SPAN));
    end

    // Column/row counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= {X_W{1'b0}};
            r_row <= {Y_W{1'b0}};
        end else if (ce) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end else if (sof) begin
            r_col <= {X_W{1'b0}};
            r_row <= {Y_W{1'b0}};
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    // New window column: entry k is row y-k at the current column.
    always_comb begin
        for (int i = 0; i < NMS_SIZE - 1; i++) begin
            w_lb_rd[i] = r_lb[i][w_col];
        end
        w_col_vec[0] = score_in;
        for (int i = 1; i < NMS_SIZE; i++) begin
            w_col_vec[i] = w_lb_rd[i-1];
        end
    end

    // Line buffers cascade: each one takes over the row the previous buffer held.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < NMS_SIZE - 1; i++) begin
                r_lb[i][w_col] <= w_col_vec[i];
            end
        end
    end

    // Stage 1: window shift (column 0 newest) and centre coordinate capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NMS_SIZE; k++) begin
                for (int j = 0; j < NMS_SIZE; j++) begin
                    r_win[k][j] <= {SCORE_W{1'b0}};
                end
            end
            r_s1_vld <= 1'b0;
            r_s1_x   <= {X_W{1'b0}};
            r_s1_y   <= {Y_W{1'b0}};
        end else begin
            r_s1_vld <= ce & w_eligible;
            if (ce) begin
                for (int k = 0; k < NMS_SIZE; k++) begin
                    r_win[k][0] <= w_col_vec[k];
                    for (int j = 1; j < NMS_SIZE; j++) begin
                        r_win[k][j] <= r_win[k][j-1];
                    end
                end
                r_s1_x <= w_col - X_W'(R);
                r_s1_y <= w_row - Y_W'(R);
            end
        end
    end

    // Raster-order tie-break: strict against earlier neighbours, >= against later ones,
    // so an equal-score plateau keeps only its first member.
    always_comb begin
        w_centre = r_win[R][R];
        w_is_max = (w_centre > w_thresh);
        for (int k = 0; k < NMS_SIZE; k++) begin
            for (int j = 0; j < NMS_SIZE; j++) begin
                if ((k > R) || ((k == R) && (j > R))) begin
                    w_is_max = w_is_max & (w_centre > r_win[k][j]);
                end else if ((k < R) || (j < R)) begin
                    w_is_max = w_is_max & (w_centre >= r_win[k][j]);
                end else begin
                    w_is_max = w_is_max;
                end
            end
        end
    end

    // Stage 2: registered result; data outputs hold between valid pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld    <= 1'b0;
            corner_out <= 1'b0;
            x_out      <= {X_W{1'b0}};
            y_out      <= {Y_W{1'b0}};
            score_out  <= {SCORE_W{1'b0}};
        end else begin
            out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                corner_out <= w_is_max;
                x_out      <= r_s1_x;
                y_out      <= r_s1_y;
                score_out  <= w_centre;
            end
        end
    end

endmodule

// File: tb/tb_nms_window_core.sv
// Scoreboard bench for nms_window_core: 3x3 and 5x5 instances on a 16x12 frame.
module tb_nms_window_core;
    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int SW   = 13;

    typedef struct {
        int x;
        int y;
        int s;
        int c;
        int cyc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          sof = 1'b0;
    logic [SW-1:0] score_in = '0;

    logic          o3_vld, o3_corner, o5_vld, o5_corner;
    logic [3:0]    o3_x, o3_y, o5_x, o5_y;
    logic [SW-1:0] o3_score, o5_score;

    ent_t q3[$], q5[$], c3[$], c5[$];
    ent_t e3, e5;
    int   img[ROWS][COLS];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   v3 = 0;
    int   v5 = 0;
    int   thr = 0;

`ifdef NMS_SCORE_THRESH_EN
    logic [SW-1:0] thr_v;
    assign thr_v = thr[SW-1:0];
`endif

    nms_window_core #(.COL_NUM(COLS), .ROW_NUM(ROWS), .NMS_SIZE(3), .SCORE_W(SW), .X_W(4), .Y_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .score_in(score_in),
`ifdef NMS_SCORE_THRESH_EN
        .score_thresh(thr_v),
`endif
        .out_vld(o3_vld), .corner_out(o3_corner), .x_out(o3_x), .y_out(o3_y), .score_out(o3_score)
    );

    nms_window_core #(.COL_NUM(COLS), .ROW_NUM(ROWS), .NMS_SIZE(5), .SCORE_W(SW), .X_W(4), .Y_W(4)) u_dut5 (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .score_in(score_in),
`ifdef NMS_SCORE_THRESH_EN
        .score_thresh(thr_v),
`endif
        .out_vld(o5_vld), .corner_out(o5_corner), .x_out(o5_x), .y_out(o5_y), .score_out(o5_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Direct frame-level reference: centre must beat earlier neighbours strictly, later ones or equal.
    function automatic int model(input int cx, input int cy, input int r);
        int c;
        int ok;
        int n;
        c  = img[cy][cx];
        ok = (c > thr) ? 1 : 0;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                n = img[cy+dy][cx+dx];
                if (dy < 0 || (dy == 0 && dx < 0)) begin
                    if (!(c > n)) ok = 0;
                end else if (dy > 0 || dx > 0) begin
                    if (!(c >= n)) ok = 0;
                end
            end
        end
        return ok;
    endfunction

    // Monitor for the 3x3 instance.
    always @(negedge clk) begin
        if (rst && o3_vld) begin
            v3 <= v3 + 1;
            if (q3.size() == 0) begin
                chk("d3 unexpected out_vld", 1, 0);
            end else begin
                e3 = q3.pop_front();
                chk("d3 x_out", int'(o3_x), e3.x);
                chk("d3 y_out", int'(o3_y), e3.y);
                chk("d3 score_out", int'(o3_score), e3.s);
                chk("d3 corner_out", int'(o3_corner), e3.c);
                chk("d3 latency cycle", cyc, e3.cyc);
            end
            if (o3_corner) c3.push_back('{int'(o3_x), int'(o3_y), int'(o3_score), 1, cyc});
        end
    end

    // Monitor for the 5x5 instance.
    always @(negedge clk) begin
        if (rst && o5_vld) begin
            v5 <= v5 + 1;
            if (q5.size() == 0) begin
                chk("d5 unexpected out_vld", 1, 0);
            end else begin
                e5 = q5.pop_front();
                chk("d5 x_out", int'(o5_x), e5.x);
                chk("d5 y_out", int'(o5_y), e5.y);
                chk("d5 score_out", int'(o5_score), e5.s);
                chk("d5 corner_out", int'(o5_corner), e5.c);
                chk("d5 latency cycle", cyc, e5.cyc);
            end
            if (o5_corner) c5.push_back('{int'(o5_x), int'(o5_y), int'(o5_score), 1, cyc});
        end
    end

    task automatic clear_img();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                img[y][x] = 0;
    endtask

    task automatic new_frame();
        c3.delete();
        c5.delete();
        v3 = 0;
        v5 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive rows 0..stop_row-1; stall inserts a ce 1-0-0-1 rhythm and a lone sof before (0,0).
    task automatic run_frame(input int stall, input int stop_row);
        if (stall != 0) begin
            sof = 1'b1;
            idle(1);
            sof = 1'b0;
        end
        for (int y = 0; y < stop_row; y++) begin
            for (int x = 0; x < COLS; x++) begin
                if (stall != 0 && ((x + y) % 3 == 0)) idle(2);
                if (x >= 2 && y >= 2)
                    q3.push_back('{x-1, y-1, img[y-1][x-1], model(x-1, y-1, 1), cyc+2});
                if (x >= 4 && y >= 4)
                    q5.push_back('{x-2, y-2, img[y-2][x-2], model(x-2, y-2, 2), cyc+2});
                sof      = (stall == 0 && x == 0 && y == 0) ? 1'b1 : 1'b0;
                ce       = 1'b1;
                score_in = img[y][x][SW-1:0];
                @(posedge clk);
                #1;
                ce  = 1'b0;
                sof = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        chk({tag, " d3 pending results"}, q3.size(), 0);
        chk({tag, " d5 pending results"}, q5.size(), 0);
    endtask

    task automatic exp_corners(input string tag, input int which, input int n, input int ex[3][3]);
        int   got;
        ent_t e;
        got = (which == 3) ? c3.size() : c5.size();
        chk({tag, " corner count"}, got, n);
        for (int i = 0; i < n && i < got; i++) begin
            e = (which == 3) ? c3[i] : c5[i];
            chk({tag, " corner x"}, e.x, ex[i][0]);
            chk({tag, " corner y"}, e.y, ex[i][1]);
            chk({tag, " corner score"}, e.s, ex[i][2]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " d3 out_vld"}, int'(o3_vld), 0);
        chk({tag, " d3 corner_out"}, int'(o3_corner), 0);
        chk({tag, " d3 x_out"}, int'(o3_x), 0);
        chk({tag, " d3 y_out"}, int'(o3_y), 0);
        chk({tag, " d3 score_out"}, int'(o3_score), 0);
        chk({tag, " d5 out_vld"}, int'(o5_vld), 0);
        chk({tag, " d5 corner_out"}, int'(o5_corner), 0);
        chk({tag, " d5 x_out"}, int'(o5_x), 0);
        chk({tag, " d5 y_out"}, int'(o5_y), 0);
        chk({tag, " d5 score_out"}, int'(o5_score), 0);
    endtask

    initial begin
        @(negedge clk);
        chk_reset_outputs("reset");
        idle(2);
        rst = 1'b1;

        // Isolated peak.
        clear_img();
        img[5][10] = 200;
        new_frame();
        run_frame(0, ROWS);
        drain("s1");
        exp_corners("s1 d3", 3, 1, '{'{10, 5, 200}, '{0, 0, 0}, '{0, 0, 0}});
        exp_corners("s1 d5", 5, 1, '{'{10, 5, 200}, '{0, 0, 0}, '{0, 0, 0}});
        chk("s1 d3 out_vld count", v3, 140);

        // Equal-score plateau: only the raster-first member survives.
        clear_img();
        img[5][5] = 80;
        img[5][6] = 80;
        new_frame();
        run_frame(0, ROWS);
        drain("s2");
        exp_corners("s2 d3", 3, 1, '{'{5, 5, 80}, '{0, 0, 0}, '{0, 0, 0}});
        exp_corners("s2 d5", 5, 1, '{'{5, 5, 80}, '{0, 0, 0}, '{0, 0, 0}});

        // Peaks on the frame edge are never reported.
        clear_img();
        img[5][0]  = 300;
        img[7][15] = 300;
        new_frame();
        run_frame(0, ROWS);
        drain("s3");
        exp_corners("s3 d3", 3, 0, '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}});
        exp_corners("s3 d5", 5, 0, '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}});

        // Stalled input with a sof that precedes pixel (0,0).
        clear_img();
        img[5][10] = 200;
        new_frame();
        run_frame(1, ROWS);
        drain("s4");
        exp_corners("s4 d3", 3, 1, '{'{10, 5, 200}, '{0, 0, 0}, '{0, 0, 0}});
        exp_corners("s4 d5", 5, 1, '{'{10, 5, 200}, '{0, 0, 0}, '{0, 0, 0}});
        chk("s4 d3 out_vld count", v3, 140);
        chk("s4 d5 out_vld count", v5, 96);

        // Window-size dependent suppression and corner eligibility.
        clear_img();
        img[5][5] = 50;
        img[7][7] = 60;
        img[1][1] = 70;
        new_frame();
        run_frame(0, ROWS);
        drain("s5");
        exp_corners("s5 d3", 3, 3, '{'{1, 1, 70}, '{5, 5, 50}, '{7, 7, 60}});
        exp_corners("s5 d5", 5, 1, '{'{7, 7, 60}, '{0, 0, 0}, '{0, 0, 0}});

        // Reset mid-frame, then a fresh frame.
        clear_img();
        img[5][10] = 200;
        new_frame();
        run_frame(0, 5);
        rst = 1'b0;
        q3.delete();
        q5.delete();
        @(negedge clk);
        chk_reset_outputs("s6 mid-frame reset");
        idle(2);
        rst = 1'b1;
        idle(3);
        new_frame();
        run_frame(0, ROWS);
        drain("s6");
        exp_corners("s6 d3", 3, 1, '{'{10, 5, 200}, '{0, 0, 0}, '{0, 0, 0}});
        exp_corners("s6 d5", 5, 1, '{'{10, 5, 200}, '{0, 0, 0}, '{0, 0, 0}});

`ifdef NMS_SCORE_THRESH_EN
        thr = 200;
        new_frame();
        run_frame(0, ROWS);
        drain("s7");
        exp_corners("s7 d3", 3, 0, '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}});
        exp_corners("s7 d5", 5, 0, '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}});
        thr = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
